// File: rtl/minmax_seq_pkg.sv
// Shared types for the min/max frame scanner.
// Holds the FSM state encoding and the sample width.
package minmax_seq_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        CMP_MAX,
        CMP_MIN,
        DONE
    } state_t;

endpackage

// File: rtl/minmax_seq_cmp.sv
// Unsigned magnitude comparator shared by the max and min passes.
// Ports: d0, d1 (operands); eq, gt, lt (d0 relative to d1).
module mag_cmp4
    import minmax_seq_pkg::*;
(
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    output logic              eq,
    output logic              gt,
    output logic              lt
);

    assign eq = (d0 == d1);
    assign gt = (d0 > d1);
    assign lt = (d0 < d1);

endmodule

// File: rtl/minmax_seq.sv
// Sequential min/max scanner: accepts a frame of len samples and reports
// the max, min and the number of times the max occurred.
// Ports: clk, rst (async, active-high); start/len open a frame;
// in_valid/in_data/in_ready carry samples; busy, done (1-cycle pulse),
// max_val, min_val, max_cnt report the result.
module minmax_seq
    import minmax_seq_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    output logic [LEN_W-1:0]  max_cnt
);

    state_t             state;
    state_t             state_nx;
    logic [LEN_W-1:0]   remaining;
    logic               first;
    logic [DATA_W-1:0]  sample;
    logic [DATA_W-1:0]  cmp_d1;
    logic               cmp_eq;
    logic               cmp_gt;
    logic               cmp_lt;
    logic               last;

    // One comparator serves both passes; its second operand follows the state.
    assign cmp_d1 = (state == CMP_MIN) ? min_val : max_val;
    assign last   = (remaining == LEN_W'(1));

    mag_cmp4 u_cmp (
        .d0 (sample),
        .d1 (cmp_d1),
        .eq (cmp_eq),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = (state != IDLE);
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len == '0) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (first) begin
                        state_nx = last ? DONE : ACCEPT;
                    end else begin
                        state_nx = CMP_MAX;
                    end
                end
            end
            CMP_MAX: state_nx = CMP_MIN;
            CMP_MIN: state_nx = last ? DONE : ACCEPT;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            first     <= 1'b0;
            sample    <= '0;
            max_val   <= '0;
            min_val   <= '0;
            max_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= len;
                        first     <= (len != '0);
                        max_val   <= '0;
                        min_val   <= '0;
                        max_cnt   <= '0;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        sample <= in_data;
                        // First sample seeds both extremes directly.
                        if (first) begin
                            max_val   <= in_data;
                            min_val   <= in_data;
                            max_cnt   <= LEN_W'(1);
                            first     <= 1'b0;
                            remaining <= remaining - LEN_W'(1);
                        end
                    end
                end
                CMP_MAX: begin
                    if (cmp_gt) begin
                        max_val <= sample;
                        max_cnt <= LEN_W'(1);
                    end else if (cmp_eq && (max_cnt != '1)) begin
                        max_cnt <= max_cnt + LEN_W'(1);
                    end
                end
                CMP_MIN: begin
                    if (cmp_lt) begin
                        min_val <= sample;
                    end
                    remaining <= remaining - LEN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
